// File: rtl/ps2_host_sequencer.sv
// PS/2 host sequencer: arbitrates the receive stream and command transmission
// between a single host port and the PS/2 receive/transmit cores. Received
// stream bytes are buffered in a small first-word-fall-through FIFO.
module ps2_host_sequencer #(
  parameter int unsigned FIFO_AW     = 2,
  parameter logic [23:0] ACK_TIMEOUT = 24'd500000,
  parameter logic [7:0]  ACK_BYTE    = 8'hFA
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic [1:0] cmd_status,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_en,
  input  logic       rx_idle,
  output logic       wait_for_incoming_data,
  output logic       send_command,
  output logic [7:0] the_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  localparam logic [1:0] STAT_OK       = 2'd0;
  localparam logic [1:0] STAT_TX_TMO   = 2'd1;
  localparam logic [1:0] STAT_BAD_ACK  = 2'd2;
  localparam logic [1:0] STAT_ACK_TMO  = 2'd3;

  typedef enum logic [2:0] {
    ST_RX    = 3'd0,
    ST_DRAIN = 3'd1,
    ST_SEND  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load_status;
  logic [1:0]         w_status_next;
  logic [1:0]         r_status;
  logic [7:0]         r_cmd;
  logic [23:0]        r_ack_cnt;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RX;
    else          r_state <= w_state_next;
  end

  // Next-state decode and completion status selection
  always_comb begin
    w_state_next  = r_state;
    w_load_status = 1'b0;
    w_status_next = r_status;
    case (r_state)
      ST_RX: begin
        if (cmd_valid) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rx_idle) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (error_communication_timed_out) begin
          w_state_next  = ST_DONE;
          w_load_status = 1'b1;
          w_status_next = STAT_TX_TMO;
        end else if (command_was_sent) begin
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        // A byte arriving in the timeout cycle takes precedence
        if (rx_byte_en) begin
          w_state_next  = ST_DONE;
          w_load_status = 1'b1;
          w_status_next = (rx_byte == ACK_BYTE) ? STAT_OK : STAT_BAD_ACK;
        end else if (r_ack_cnt == ACK_TIMEOUT) begin
          w_state_next  = ST_DONE;
          w_load_status = 1'b1;
          w_status_next = STAT_ACK_TMO;
        end
      end
      ST_DONE: w_state_next = ST_RX;
      default: w_state_next = ST_RX;
    endcase
  end

  // Command latch, status hold and ACK wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd     <= 8'd0;
      r_status  <= STAT_OK;
      r_ack_cnt <= 24'd0;
    end else begin
      if (r_state == ST_RX && cmd_valid) r_cmd <= cmd_data;
      if (w_load_status)                 r_status <= w_status_next;
      if (r_state == ST_ACK) r_ack_cnt <= r_ack_cnt + 24'd1;
      else                   r_ack_cnt <= 24'd0;
    end
  end

  assign cmd_ready              = (r_state == ST_RX);
  assign cmd_done               = (r_state == ST_DONE);
  assign cmd_status             = r_status;
  assign wait_for_incoming_data = (r_state == ST_RX) || (r_state == ST_ACK);
  assign send_command           = (r_state == ST_SEND);
  assign the_command            = r_cmd;

  // FIFO control: ACK-phase bytes belong to the command, not the stream
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == CNT_W'(0));
  assign w_push_req = rx_byte_en && (r_state != ST_ACK);
  assign w_pop      = rd_en && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);

  // FIFO storage, pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= rx_byte;
        r_wptr        <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      else if (clear_overflow)   r_overflow <= 1'b0;
    end
  end

  assign rd_data  = r_mem[r_rptr];
  assign rd_valid = !w_empty;
  assign overflow = r_overflow;

endmodule
